// File: rtl/bnn_pkg.sv
// Shared BNN definitions: top-level state encodings, buffer geometry and stream width.
// Used by input_loader, the conv/pool layers and the top FSM.
package bnn_pkg;

  localparam logic [2:0] s_IDLE    = 3'b000;
  localparam logic [2:0] s_LOAD    = 3'b001;
  localparam logic [2:0] s_LAYER_1 = 3'b010;
  localparam logic [2:0] s_LAYER_2 = 3'b011;
  localparam logic [2:0] s_LAYER_3 = 3'b100;

  localparam int PIX_BITS  = 784;
  localparam int WT_BITS   = 72;
  localparam int BUS_W     = 8;
  localparam int PIX_BEATS = PIX_BITS / BUS_W;
  localparam int WT_BEATS  = WT_BITS / BUS_W;

  typedef logic [2:0]       top_state_t;
  typedef logic [BUS_W-1:0] beat_t;

  function automatic beat_t csum_fold(input beat_t acc, input beat_t d);
    return acc ^ d;
  endfunction

endpackage

// File: rtl/input_loader_if.sv
// Byte-stream handshake feeding the input loader: source drives data/valid, loader drives ready.
interface input_loader_if;
  import bnn_pkg::*;

  logic [BUS_W-1:0] data_in;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_in, output data_valid, input  data_ready);
  modport slave  (input  data_in, input  data_valid, output data_ready);

endinterface

// File: rtl/input_loader.sv
// Writer side of the BNN input buffers: packs the load stream into pixels then weights.
// Build macro INPUT_LOADER_CHECKSUM_EN adds a trailing XOR checksum beat and load_err.
module input_loader
  import bnn_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          state,
  input_loader_if.slave       stream,
  output logic [PIX_BITS-1:0] pixels,
  output logic [WT_BITS-1:0]  weights,
  output logic                load_done,
  output logic                load_err
);

  localparam logic [1:0] L_PIX  = 2'b00;
  localparam logic [1:0] L_WT   = 2'b01;
`ifdef INPUT_LOADER_CHECKSUM_EN
  localparam logic [1:0] L_CSUM = 2'b10;
`endif
  localparam logic [1:0] L_DONE = 2'b11;

  logic [1:0]          fsm_r;
  logic [6:0]          beat_cnt_r;
  logic [PIX_BITS-1:0] pixels_r;
  logic [WT_BITS-1:0]  weights_r;
  logic                load_done_r;

  logic                data_ready_s;
  logic                accept_s;
  logic                pix_we_s;
  logic                wt_we_s;
  logic                last_pix_s;
  logic                last_wt_s;
  logic [9:0]          pix_base_s;
  logic [6:0]          wt_base_s;

  // Ready never looks at valid, so a source may wait on ready without a loop.
  assign data_ready_s      = (state == s_LOAD) && (fsm_r != L_DONE);
  assign stream.data_ready = data_ready_s;
  assign accept_s          = stream.data_valid && data_ready_s;
  assign last_pix_s        = (beat_cnt_r == 7'(PIX_BEATS - 1));
  assign last_wt_s         = (beat_cnt_r == 7'(WT_BEATS - 1));
  assign pix_base_s        = 10'(beat_cnt_r) * 10'(BUS_W);
  assign wt_base_s         = beat_cnt_r * 7'(BUS_W);

`ifdef INPUT_LOADER_CHECKSUM_EN
  logic       csum_we_s;
  logic [BUS_W-1:0] csum_acc_r;
  logic       load_err_r;
`endif

  // Route an accepted beat to the buffer selected by the load phase.
  always_comb begin
    pix_we_s  = 1'b0;
    wt_we_s   = 1'b0;
`ifdef INPUT_LOADER_CHECKSUM_EN
    csum_we_s = 1'b0;
`endif
    if (accept_s) begin
      case (fsm_r)
        L_PIX:   pix_we_s  = 1'b1;
        L_WT:    wt_we_s   = 1'b1;
`ifdef INPUT_LOADER_CHECKSUM_EN
        L_CSUM:  csum_we_s = 1'b1;
`endif
        default: pix_we_s  = 1'b0;
      endcase
    end else begin
      pix_we_s = 1'b0;
    end
  end

  // Load-phase FSM and beat counter; s_IDLE rewinds, layer states simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r       <= L_PIX;
      beat_cnt_r  <= 7'd0;
      load_done_r <= 1'b0;
    end else if (state == s_IDLE) begin
      fsm_r       <= L_PIX;
      beat_cnt_r  <= 7'd0;
      load_done_r <= 1'b0;
    end else if (pix_we_s) begin
      if (last_pix_s) begin
        beat_cnt_r <= 7'd0;
        fsm_r      <= L_WT;
      end else begin
        beat_cnt_r <= beat_cnt_r + 7'd1;
      end
    end else if (wt_we_s) begin
      if (last_wt_s) begin
        beat_cnt_r  <= 7'd0;
`ifdef INPUT_LOADER_CHECKSUM_EN
        fsm_r       <= L_CSUM;
`else
        fsm_r       <= L_DONE;
        load_done_r <= 1'b1;
`endif
      end else begin
        beat_cnt_r <= beat_cnt_r + 7'd1;
      end
`ifdef INPUT_LOADER_CHECKSUM_EN
    end else if (csum_we_s) begin
      fsm_r       <= L_DONE;
      load_done_r <= 1'b1;
`endif
    end
  end

  // Buffers survive s_IDLE so the previous image stays readable until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixels_r  <= '0;
      weights_r <= '0;
    end else begin
      if (pix_we_s) begin
        pixels_r[pix_base_s +: BUS_W] <= stream.data_in;
      end
      if (wt_we_s) begin
        weights_r[wt_base_s +: BUS_W] <= stream.data_in;
      end
    end
  end

`ifdef INPUT_LOADER_CHECKSUM_EN
  // XOR accumulator over all data beats, compared against the trailing checksum beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_acc_r <= '0;
      load_err_r <= 1'b0;
    end else if (state == s_IDLE) begin
      csum_acc_r <= '0;
      load_err_r <= 1'b0;
    end else if (pix_we_s || wt_we_s) begin
      csum_acc_r <= csum_fold(csum_acc_r, stream.data_in);
    end else if (csum_we_s) begin
      load_err_r <= (stream.data_in != csum_acc_r);
    end
  end

  assign load_err = load_err_r;
`else
  assign load_err = 1'b0;
`endif

  assign pixels    = pixels_r;
  assign weights   = weights_r;
  assign load_done = load_done_r;

endmodule
